// File: rtl/accum_window_looper_pkg.sv
// Shared definitions for the accumulation-window looper.
// Contents:
//   BW_DEF    default offset width
//   VDIM_DEF  default number of window dimensions
//   state_e   looper control state (IDLE accepts a block, RUN presents points)
package accum_window_looper_pkg;

    localparam int BW_DEF   = 16;
    localparam int VDIM_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/accum_window_looper_nd_window_counter.sv
// nd_window_counter: N-dimensional [beg,end) counter with a unit-stride
// carry chain. Dimension N-1 is the fastest; a dimension sitting at end-1
// wraps to its begin value and carries into the next slower dimension.
// Alongside the count it keeps a registered sum = base + count, so the
// owner gets an offset output without an adder stage after the flops.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        capture load_beg/load_end/load_base, count starts at load_beg
//   step        advance the count by one point
//   load_beg    per-dim begin (inclusive)
//   load_end    per-dim end (exclusive)
//   load_base   per-dim base added to the count
//   sum         registered base + current count, truncated to W bits
//   at_last     every dim at end-1; also the carry out of dim 0 on step
module nd_window_counter #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [N-1:0][W-1:0] load_beg,
    input  logic [N-1:0][W-1:0] load_end,
    input  logic [N-1:0][W-1:0] load_base,
    output logic [N-1:0][W-1:0] sum,
    output logic                at_last
);

    logic [N-1:0][W-1:0] beg_q;
    logic [N-1:0][W-1:0] end_q;
    logic [N-1:0][W-1:0] base_q;
    logic [N-1:0][W-1:0] cur_q;
    logic [N-1:0][W-1:0] nxt;
    logic [N-1:0]        at_end;
    logic [N:0]          carry;

    // carry[d+1] is the carry arriving at dim d; carry[N] is the step itself.
    always_comb begin
        at_end   = '0;
        nxt      = cur_q;
        carry    = '0;
        carry[N] = 1'b1;
        for (int d = N - 1; d >= 0; d--) begin
            at_end[d] = (cur_q[d] == end_q[d] - W'(1));
            if (carry[d+1]) begin
                nxt[d] = at_end[d] ? beg_q[d] : cur_q[d] + W'(1);
            end
            carry[d] = carry[d+1] & at_end[d];
        end
    end

    assign at_last = carry[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beg_q  <= '0;
            end_q  <= '0;
            base_q <= '0;
            cur_q  <= '0;
            sum    <= '0;
        end else if (load) begin
            beg_q  <= load_beg;
            end_q  <= load_end;
            base_q <= load_base;
            cur_q  <= load_beg;
            for (int d = 0; d < N; d++) begin
                sum[d] <= load_base[d] + load_beg[d];
            end
        end else if (step) begin
            cur_q <= nxt;
            for (int d = 0; d < N; d++) begin
                sum[d] <= base_q[d] + nxt[d];
            end
        end
    end

endmodule

// File: rtl/accum_window_looper.sv
// accum_window_looper: expands one accumulation block (base offset, VDIM-dim
// [aofs_beg,aofs_end) window, cfg id range [beg,end)) into a point stream.
// The cfg id is the outer loop, the window the inner loop (last dim fastest).
// Ports:
//   i_clk, i_rst            clock and asynchronous active-low reset
//   src_rdy/src_ack         block offer / 1-cycle accept pulse (combinational)
//   i_bofs                  block base offset, per dim
//   i_aofs_beg/i_aofs_end   window begin (incl) / end (excl), per dim
//   i_beg/i_end             cfg id range [beg,end)
//   dst_rdy/dst_ack         point valid / point consumed
//   o_id, o_ofs, o_islast   current point: id, bofs+aofs (mod 2^BW), last flag
//   done_dval               1-cycle pulse when the block is finished
//   dbg_state               current control state
// Handshakes: src_ack rises only in IDLE while src_rdy is high and the block
// is taken on that edge. dst_rdy stays high with o_* stable until dst_ack;
// each cycle with dst_rdy && dst_ack consumes exactly one point.
module accum_window_looper
    import accum_window_looper_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int VDIM  = VDIM_DEF,
    parameter int ID_BW = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   src_rdy,
    output logic                   src_ack,
    input  logic [VDIM-1:0][BW-1:0] i_bofs,
    input  logic [VDIM-1:0][BW-1:0] i_aofs_beg,
    input  logic [VDIM-1:0][BW-1:0] i_aofs_end,
    input  logic [ID_BW-1:0]       i_beg,
    input  logic [ID_BW-1:0]       i_end,
    output logic                   dst_rdy,
    input  logic                   dst_ack,
    output logic [ID_BW-1:0]       o_id,
    output logic [VDIM-1:0][BW-1:0] o_ofs,
    output logic                   o_islast,
    output logic                   done_dval,
    output state_e                 dbg_state
);

    state_e state_q;
    state_e state_d;

    logic              blk_empty;
    logic              accept;
    logic              advance;
    logic              win_last;
    logic              id_last;
    logic [0:0][ID_BW-1:0] id_sum;

    // An empty id range or any empty window dim yields no points at all.
    always_comb begin
        blk_empty = (i_beg >= i_end);
        for (int d = 0; d < VDIM; d++) begin
            if (i_aofs_beg[d] >= i_aofs_end[d]) begin
                blk_empty = 1'b1;
            end
        end
    end

    nd_window_counter #(
        .N (VDIM),
        .W (BW)
    ) u_win (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .load      (accept),
        .step      (advance),
        .load_beg  (i_aofs_beg),
        .load_end  (i_aofs_end),
        .load_base (i_bofs),
        .sum       (o_ofs),
        .at_last   (win_last)
    );

    // Id loop: one dimension, zero base, steps only on window carry-out.
    nd_window_counter #(
        .N (1),
        .W (ID_BW)
    ) u_id (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .load      (accept),
        .step      (advance & win_last),
        .load_beg  (i_beg),
        .load_end  (i_end),
        .load_base ('0),
        .sum       (id_sum),
        .at_last   (id_last)
    );

    assign o_id      = id_sum[0];
    assign o_islast  = (state_q == RUN) & win_last & id_last;
    assign dbg_state = state_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_ack   = 1'b0;
        dst_rdy   = 1'b0;
        done_dval = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (src_rdy) begin
                    src_ack = 1'b1;
                    if (blk_empty) begin
                        done_dval = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                dst_rdy = 1'b1;
                if (dst_ack) begin
                    advance = 1'b1;
                    if (o_islast) begin
                        done_dval = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_accum_window_looper.sv
// Scoreboarded bench for accum_window_looper (VDIM=2, BW=16, ID_BW=3).
// The driver pushes every expected point {islast, id, ofs[1], ofs[0]} when
// it offers a block; a negedge monitor pops and compares on each consumed
// point and checks held points against the queue head.
module tb_accum_window_looper;
    import accum_window_looper_pkg::*;

    localparam int BW    = 16;
    localparam int VDIM  = 2;
    localparam int ID_BW = 3;
    localparam int EW    = 1 + ID_BW + VDIM * BW;

    logic                    i_clk = 1'b0;
    logic                    i_rst = 1'b0;
    logic                    src_rdy = 1'b0;
    logic                    src_ack;
    logic [VDIM-1:0][BW-1:0] i_bofs = '0;
    logic [VDIM-1:0][BW-1:0] i_aofs_beg = '0;
    logic [VDIM-1:0][BW-1:0] i_aofs_end = '0;
    logic [ID_BW-1:0]        i_beg = '0;
    logic [ID_BW-1:0]        i_end = '0;
    logic                    dst_rdy;
    logic                    dst_ack = 1'b0;
    logic [ID_BW-1:0]        o_id;
    logic [VDIM-1:0][BW-1:0] o_ofs;
    logic                    o_islast;
    logic                    done_dval;
    state_e                  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int acks_seen = 0;
    bit allow_done = 1'b0;
    bit bp_en = 1'b0;
    logic [EW-1:0] exp_q[$];

    accum_window_looper #(
        .BW    (BW),
        .VDIM  (VDIM),
        .ID_BW (ID_BW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .src_rdy    (src_rdy),
        .src_ack    (src_ack),
        .i_bofs     (i_bofs),
        .i_aofs_beg (i_aofs_beg),
        .i_aofs_end (i_aofs_end),
        .i_beg      (i_beg),
        .i_end      (i_end),
        .dst_rdy    (dst_rdy),
        .dst_ack    (dst_ack),
        .o_id       (o_id),
        .o_ofs      (o_ofs),
        .o_islast   (o_islast),
        .done_dval  (done_dval),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- helpers ----------------
    function automatic logic [VDIM-1:0][BW-1:0] v2(input int d0, input int d1);
        logic [VDIM-1:0][BW-1:0] v;
        v[0] = BW'(d0);
        v[1] = BW'(d1);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- consumer ----------------
    always @(posedge i_clk) begin
        #1;
        dst_ack = dst_rdy && (bp_en ? ($urandom_range(0, 1) == 1) : 1'b1);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        logic [EW-1:0] act;
        if (i_rst) begin
            act = {o_islast, o_id, o_ofs};
            if (dst_rdy) begin
                check("src_ack_while_run", {63'b0, src_ack}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_point", {63'b0, dst_rdy}, 64'd0);
                end else if (dst_ack) begin
                    check("point", 64'(act), 64'(exp_q[0]));
                    check("done_with_ack", {63'b0, done_dval}, {63'b0, exp_q[0][EW-1]});
                    void'(exp_q.pop_front());
                    acks_seen++;
                end else begin
                    check("point_hold", 64'(act), 64'(exp_q[0]));
                    check("done_while_held", {63'b0, done_dval}, 64'd0);
                end
            end else if (done_dval && !allow_done) begin
                check("spurious_done", {63'b0, done_dval}, 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_block(input logic [VDIM-1:0][BW-1:0] bofs,
                              input logic [VDIM-1:0][BW-1:0] ab,
                              input logic [VDIM-1:0][BW-1:0] ae,
                              input logic [ID_BW-1:0] b,
                              input logic [ID_BW-1:0] e);
        bit is_empty;
        bit got;
        bit last;
        logic [BW-1:0] o0;
        logic [BW-1:0] o1;
        is_empty = (b >= e) || (ab[0] >= ae[0]) || (ab[1] >= ae[1]);
        for (int id = int'(b); id < int'(e); id++) begin
            for (int a0 = int'(ab[0]); a0 < int'(ae[0]); a0++) begin
                for (int a1 = int'(ab[1]); a1 < int'(ae[1]); a1++) begin
                    last = (id == int'(e) - 1) && (a0 == int'(ae[0]) - 1) && (a1 == int'(ae[1]) - 1);
                    o0 = bofs[0] + BW'(a0);
                    o1 = bofs[1] + BW'(a1);
                    exp_q.push_back({last, ID_BW'(id), o1, o0});
                end
            end
        end
        @(posedge i_clk);
        #1;
        i_bofs     = bofs;
        i_aofs_beg = ab;
        i_aofs_end = ae;
        i_beg      = b;
        i_end      = e;
        src_rdy    = 1'b1;
        allow_done = is_empty;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge i_clk);
            if (src_ack) got = 1'b1;
        end
        check("src_ack_seen", {63'b0, got}, 64'd1);
        check(is_empty ? "empty_done" : "accept_no_done", {63'b0, done_dval}, {63'b0, is_empty});
        @(posedge i_clk);
        #1;
        src_rdy    = 1'b0;
        allow_done = 1'b0;
        // Scramble inputs: the looper must run from its latched copy.
        i_bofs     = v2(16'h5a5a, 16'h1234);
        i_aofs_beg = v2(0, 0);
        i_aofs_end = v2(9, 9);
        i_beg      = '0;
        i_end      = 3'd7;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 500 && (exp_q.size() != 0 || dst_rdy); t++) begin
            @(negedge i_clk);
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(negedge i_clk);
        check({name, "_idle"}, {63'b0, dst_rdy}, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(negedge i_clk);
        check("rst_src_ack", {63'b0, src_ack}, 64'd0);
        check("rst_dst_rdy", {63'b0, dst_rdy}, 64'd0);
        check("rst_done", {63'b0, done_dval}, 64'd0);
        check("rst_id", 64'(o_id), 64'd0);
        check("rst_ofs", 64'(o_ofs), 64'd0);
        check("rst_islast", {63'b0, o_islast}, 64'd0);
        check("rst_state", {63'b0, dbg_state}, {63'b0, IDLE});
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;

        // 2x3 window, ids 1..2 -> 12 points; then a wrap block offered while it runs.
        send_block(v2(10, 20), v2(0, 0), v2(2, 3), 3'd1, 3'd3);
        send_block(v2(16'hffff, 16'hffff), v2(2, 2), v2(3, 3), 3'd0, 3'd1);
        drain("drain_basic_wrap");

        // Empty id range and empty window dimension.
        send_block(v2(0, 0), v2(0, 0), v2(1, 1), 3'd3, 3'd3);
        send_block(v2(1, 1), v2(0, 5), v2(4, 5), 3'd0, 3'd2);
        drain("drain_empty");

        // Backpressure: single point held until acked, then a full block.
        bp_en = 1'b1;
        send_block(v2(100, 200), v2(7, 9), v2(8, 10), 3'd5, 3'd6);
        drain("drain_single_bp");
        send_block(v2(10, 20), v2(0, 0), v2(2, 3), 3'd1, 3'd3);
        drain("drain_full_bp");
        bp_en = 1'b0;

        // Reset in the middle of a 12-point block.
        acks_seen = 0;
        send_block(v2(10, 20), v2(0, 0), v2(2, 3), 3'd1, 3'd3);
        for (int t = 0; t < 100 && acks_seen < 3; t++) begin
            @(negedge i_clk);
        end
        check("acks_before_reset", {63'b0, acks_seen >= 3}, 64'd1);
        #1;
        i_rst = 1'b0;
        #1;
        check("async_rst_dst_rdy", {63'b0, dst_rdy}, 64'd0);
        check("async_rst_ofs", 64'(o_ofs), 64'd0);
        check("async_rst_id", 64'(o_id), 64'd0);
        check("async_rst_islast", {63'b0, o_islast}, 64'd0);
        check("async_rst_done", {63'b0, done_dval}, 64'd0);
        exp_q.delete();
        @(negedge i_clk);
        check("no_done_in_reset", {63'b0, done_dval}, 64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;

        // A fresh block after reset.
        send_block(v2(1, 1), v2(3, 4), v2(4, 5), 3'd2, 3'd3);
        drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
